mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the shared `Mem` main-memory model. It owns the single `Mem` port and serves two requesters: instruction fetch (port 0) and load/store (port 1). For each granted request it drives single-word or burst transfers, and returns read data and beat strobes to the winner. It sits between the pipeline's fetch/memory stages and `Mem`.

## Interface
- `MEM_RD_LAT`, default 2: cycles from the first read beat presented on `Mem` to the first valid `mem_data_out`. Legal range 1..7.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `req[0:1]` input 2: per-port request. Held high, with `addr/acc_size/wren` stable, until that port's `done`.
- `p0_addr`, `p1_addr` input ADDR_W each: start address.
- `p0_acc_size`, `p1_acc_size` input 2 each: burst size; 00=1, 01=4, 10=8, 11=16 words.
- `p0_wren`, `p1_wren` input 1 each: 1=write, 0=read.
- `p0_wdata`, `p1_wdata` input DATA_W each: current write beat.
- `gnt[0:1]` output 2: high for the whole transaction of the owning port.
- `beat[0:1]` output 2: write beat consumed, or read beat valid, this cycle.
- `done[0:1]` output 2: one-cycle pulse on the last beat.
- `rdata` output DATA_W: `mem_data_out` passed through; qualified by `beat`.
- `mem_addr` output ADDR_W: connects to `Mem` addr.
- `mem_data_in` output DATA_W: connects to `Mem` data_in.
- `mem_acc_size` output 2: connects to `Mem` acc_size.
- `mem_wren` output 1: connects to `Mem` wren.
- `mem_enable` output 1: connects to `Mem` enable.
- `mem_data_out` input DATA_W: connects to `Mem` data_out.
- `mem_busy` input 1: connects to `Mem` busy.

## Operation
- FSM states: IDLE, WRITE, RD_WAIT, READ.
- **IDLE**
  - `mem_enable=0`.
  - If any `req` is high, latch the winner's addr, acc_size and wren. Set `gnt[w]`. Load the beat counter with the burst length minus 1.
  - Next state is WRITE if wren=1. Otherwise RD_WAIT, with the latency counter loaded to `MEM_RD_LAT-1`.
- **WRITE**
  - `mem_enable=1`, `mem_wren=1`, `mem_addr` = latched start address, `mem_acc_size` = latched size.
  - `mem_data_in` = winner's `pX_wdata`, passed through combinationally.
  - `beat[w]=1` in each cycle with `mem_busy=0`; the counter decrements on each such beat.
  - On the last beat, `done[w]=1`; next state is IDLE.
- **RD_WAIT**
  - `mem_enable=1`, `mem_wren=0`, address and size held.
  - Latency counter decrements each cycle; go to READ when it reaches 0.
  - With `MEM_RD_LAT=1`, RD_WAIT lasts one cycle.
- **READ**
  - Enable, address and size held.
  - `beat[w]=1` each cycle with `mem_busy=0`; the counter decrements.
  - Last beat: `done[w]=1`, next state IDLE.
- `mem_busy=1` in WRITE or READ stalls everything: no beat, counter held, all Mem outputs held.
- Arbitration happens only in IDLE. A request arriving mid-transaction waits.
- Default arbitration is round-robin. On a tie, the port not granted last wins. The last-granted pointer resets to 0, so port 1 wins the first tie.
- Unused `mem_*` outputs in IDLE: addr 0, data_in 0, acc_size 00, wren 0.
- Beat counter is 4 bits and never wraps: 16-word bursts load 15.

## Timing
- Reset values: `gnt`, `beat`, `done` = 0; all `mem_*` outputs = 0; state IDLE; counters 0; RR pointer 0.
- Reset asserted mid-transaction aborts immediately, with `mem_enable` low asynchronously. There is no completion pulse.
- Cycle numbering: request sampled in IDLE at cycle 0. First Mem beat at cycle 1.
- Write of N words: beats in cycles 1..N, `done` in cycle N.
- Read of N words: RD_WAIT during cycles 1..`MEM_RD_LAT`. Data beats in cycles `MEM_RD_LAT`+1 .. `MEM_RD_LAT`+N. `done` on the last of those.
- Turnaround: one IDLE cycle between consecutive transactions, so the next grant occurs the cycle after `done`.
- `gnt` rises in cycle 1 and falls the cycle after `done`.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: port 1 (data) always wins ties, and the RR pointer is not built.
- Undefined: round-robin as above.

## Structure
- `mem_arb_pkg` contains:
  - the state enum;
  - acc_size encodings (`ACC_1W`, `ACC_4W`, `ACC_8W`, `ACC_16W`);
  - a burst-length function (acc_size → beats minus 1);
  - `MEM_START_ADDR = 32'h8002_0000`.
- Sub-module `mem_arb_rr`: 2-way round-robin picker. Inputs are req and pointer; outputs are a one-hot winner and the updated pointer. Compiled out under `MEM_ARB_FIXED_PRIO_EN`.

## Test plan
- **Single write then read.** Port 1 writes 0x55CC55CC at 0x80020000, size 00, then reads it back.
  - `done[1]` in cycle 1 of the write.
  - Read `beat[1]` with `rdata=0x55CC55CC` in cycle 3 (`MEM_RD_LAT`=2).
- **4-word burst.** Port 0 writes 0x55CC55CD/CE/CF/C1 from 0x80020004 with size 01, then reads them back.
  - Read returns the same four words on 4 consecutive beats.
  - `done[0]` on the 4th beat.
- **Simultaneous requests from reset.**
  - Port 1 is granted first and port 0 next.
  - Under `MEM_ARB_FIXED_PRIO_EN`, with port 1 re-requesting, port 1 is granted twice in a row.
- **`mem_busy` stall.** Busy is held for 2 cycles mid-burst during a 4-word read.
  - No `beat` during the stall; `mem_addr` and `mem_acc_size` stay stable.
  - Total beats = 4.
- **Reset mid-burst.** `reset_n` goes low during beat 2 of a 16-word write.
  - `mem_enable`, `gnt` and `beat` drop immediately; no `done` pulse.
  - After release, a fresh request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types, access-size encodings and helpers for the mem_arbiter slice.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2,
    READ    = 2'd3
  } arb_state_e;

  localparam logic [1:0] ACC_1W  = 2'b00;
  localparam logic [1:0] ACC_4W  = 2'b01;
  localparam logic [1:0] ACC_8W  = 2'b10;
  localparam logic [1:0] ACC_16W = 2'b11;

  localparam logic [31:0] MEM_START_ADDR = 32'h8002_0000;

  // Burst length minus one, the value loaded into the 4-bit beat counter.
  function automatic logic [3:0] burst_len_m1(input logic [1:0] acc_size);
    logic [3:0] len;
    case (acc_size)
      ACC_4W:  len = 4'd3;
      ACC_8W:  len = 4'd7;
      ACC_16W: len = 4'd15;
      default: len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a tie the port not granted last wins.
// Not built when MEM_ARB_FIXED_PRIO_EN is defined.
`ifndef MEM_ARB_FIXED_PRIO_EN
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt_oh,
  output logic       ptr_nxt
);

  always_comb begin
    gnt_oh  = 2'b00;
    ptr_nxt = ptr;
    case (req)
      2'b01:   gnt_oh = 2'b01;
      2'b10:   gnt_oh = 2'b10;
      2'b11:   gnt_oh = ptr ? 2'b01 : 2'b10;
      default: gnt_oh = 2'b00;
    endcase
    if (gnt_oh != 2'b00) ptr_nxt = gnt_oh[1];
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer owning the single Mem port (fetch = port 0, load/store = port 1).
// Define MEM_ARB_FIXED_PRIO_EN to give port 1 every tie and drop the round-robin pointer.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [1:0]        p0_acc_size,
  input  logic [1:0]        p1_acc_size,
  input  logic              p0_wren,
  input  logic              p1_wren,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [1:0]        gnt,
  output logic [1:0]        beat,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_acc_size,
  output logic              mem_wren,
  output logic              mem_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_busy
);

  localparam int unsigned LAT_W  = 3;
  localparam int unsigned BEAT_W = 4;

  arb_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              owner_q, owner_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              wren_q, wren_d;
  logic              en_q, en_d;

  logic [1:0]        win_oh_c;
  logic              win_c;
  logic              xfer_c;
  logic              last_c;
  logic [1:0]        owner_oh_c;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign win_oh_c = req[1] ? 2'b10 : {1'b0, req[0]};
`else
  logic rr_ptr_q, rr_ptr_d, rr_ptr_nxt_c;

  mem_arb_rr u_rr (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_oh  (win_oh_c),
    .ptr_nxt (rr_ptr_nxt_c)
  );

  // Pointer only moves when a grant is actually issued.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((state_q == IDLE) && (req != 2'b00)) rr_ptr_d = rr_ptr_nxt_c;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= 1'b0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign win_c      = win_oh_c[1];
  assign xfer_c     = ((state_q == WRITE) || (state_q == READ)) && !mem_busy;
  assign last_c     = xfer_c && (beat_cnt_q == '0);
  assign owner_oh_c = owner_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wren_d     = wren_q;
    en_d       = en_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          owner_d    = win_c;
          gnt_d      = win_oh_c;
          addr_d     = win_c ? p1_addr : p0_addr;
          size_d     = win_c ? p1_acc_size : p0_acc_size;
          wren_d     = win_c ? p1_wren : p0_wren;
          beat_cnt_d = burst_len_m1(size_d);
          en_d       = 1'b1;
          if (wren_d) begin
            state_d = WRITE;
          end else begin
            state_d   = RD_WAIT;
            lat_cnt_d = LAT_W'(MEM_RD_LAT - 1);
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt_q == '0) state_d = READ;
        else                 lat_cnt_d = lat_cnt_q - LAT_W'(1);
      end
      WRITE, READ: begin
        // Busy freezes the counter and every registered Mem output.
        if (last_c) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          addr_d  = '0;
          size_d  = ACC_1W;
          wren_d  = 1'b0;
          en_d    = 1'b0;
        end else if (xfer_c) begin
          beat_cnt_d = beat_cnt_q - BEAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      lat_cnt_q  <= '0;
      owner_q    <= 1'b0;
      gnt_q      <= 2'b00;
      addr_q     <= '0;
      size_q     <= ACC_1W;
      wren_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wren_q     <= wren_d;
      en_q       <= en_d;
    end
  end

  assign gnt          = gnt_q;
  assign beat         = xfer_c ? owner_oh_c : 2'b00;
  assign done         = last_c ? owner_oh_c : 2'b00;
  assign rdata        = mem_data_out;
  assign mem_addr     = addr_q;
  assign mem_acc_size = size_q;
  assign mem_wren     = wren_q;
  assign mem_enable   = en_q;
  assign mem_data_in  = (state_q == WRITE) ? (owner_q ? p1_wdata : p0_wdata) : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level timeline model predicts every output per cycle.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 2;
  localparam int NC  = 8192;
  localparam int QD  = 128;

  logic        clock, reset_n;
  logic [1:0]  req, gnt, beat, done;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata, rdata;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic [1:0]  p0_acc_size, p1_acc_size, mem_acc_size;
  logic        p0_wren, p1_wren, mem_wren, mem_enable, mem_busy;

  mem_arbiter #(.MEM_RD_LAT(LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .req(req),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_acc_size(p0_acc_size), .p1_acc_size(p1_acc_size),
    .p0_wren(p0_wren), .p1_wren(p1_wren),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .gnt(gnt), .beat(beat), .done(done), .rdata(rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_acc_size(mem_acc_size),
    .mem_wren(mem_wren), .mem_enable(mem_enable),
    .mem_data_out(mem_data_out), .mem_busy(mem_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  beat;
    logic [1:0]  done;
    logic        en;
    logic        wren;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic        rd_chk;
    logic        wr_chk;
    logic [3:0]  widx;
  } exp_t;

  typedef struct packed {
    logic [31:0]        addr;
    logic [1:0]         size;
    logic               wren;
    logic [15:0][31:0]  data;
  } txn_t;

  exp_t        exp_tab [NC];
  logic        busy_tab [NC];
  txn_t        txq [2][QD];
  int          q_head [2];
  int          q_tail [2];
  int          act_end [2];
  int          obs_beats [2];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem_st  [logic [31:0]];
  int          cyc, next_free, en_cnt, ridx, widx_m;
  logic        last_w;
  int          n_checks, n_pass;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_st.exists(a) ? mem_st[a] : dflt(a);
  endfunction

  function automatic int blen(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  task automatic push(input int p, input logic [31:0] a, input logic [1:0] s,
                      input logic w, input logic [15:0][31:0] d);
    if (q_tail[p] >= QD) begin
      $display("FAIL queue_overflow port=%0d", p);
      $fatal(1, "queue overflow");
    end
    txq[p][q_tail[p]] = {a, s, w, d};
    q_tail[p]++;
  endtask

  // Lay out the whole timeline of one granted transaction from its IDLE sample cycle c.
  task automatic schedule(input int c, input int w);
    txn_t t;
    exp_t e;
    int k, n, b;
    logic [1:0] oh;
    t  = txq[w][q_head[w]];
    n  = blen(t.size);
    oh = (w == 1) ? 2'b10 : 2'b01;
    k  = c + 1;
    if (!t.wren) begin
      for (int i = 0; i < LAT; i++) begin
        e = '0; e.gnt = oh; e.en = 1'b1; e.addr = t.addr; e.size = t.size;
        exp_tab[k] = e;
        k++;
      end
    end
    b = 0;
    while (b < n) begin
      e = '0; e.gnt = oh; e.en = 1'b1; e.wren = t.wren; e.addr = t.addr; e.size = t.size;
      e.wr_chk = t.wren; e.widx = 4'(b);
      if (!busy_tab[k]) begin
        e.beat = oh;
        if (t.wren) ref_mem[t.addr + 32'(4 * b)] = t.data[b];
        else begin
          e.rd_chk = 1'b1;
          e.rdata  = ref_rd(t.addr + 32'(4 * b));
        end
        if (b == n - 1) e.done = oh;
        b++;
      end
      exp_tab[k] = e;
      k++;
    end
    act_end[w] = k - 1;
    next_free  = k;
    last_w     = (w == 1);
  endtask

  task automatic reset_model();
    for (int i = 0; i < NC; i++) exp_tab[i] = '0;
    for (int p = 0; p < 2; p++) begin
      q_head[p]  = q_tail[p];
      act_end[p] = -1;
    end
    next_free = 0; last_w = 1'b0; en_cnt = 0; ridx = 0; widx_m = 0;
  endtask

  task automatic step();
    exp_t e;
    logic [1:0] r;
    txn_t h [2];
    logic [31:0] wd [2];
    int w;
    @(posedge clock);
    #1;
    cyc++;
    if (cyc >= NC - 64) begin
      $display("FAIL cycle_budget cyc=%0d", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    for (int p = 0; p < 2; p++) begin
      r[p] = (q_head[p] != q_tail[p]);
      if (r[p]) h[p] = txq[p][q_head[p]];
      else      h[p] = {32'($urandom()), 2'($urandom()), 1'($urandom()), 512'(0)};
    end
    if ((cyc >= next_free) && (r != 2'b00)) begin
      if (r == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        w = 1;
`else
        w = last_w ? 0 : 1;
`endif
      end else begin
        w = r[1] ? 1 : 0;
      end
      schedule(cyc, w);
    end
    e = exp_tab[cyc];
    for (int p = 0; p < 2; p++)
      wd[p] = (e.gnt[p] && e.wr_chk) ? h[p].data[e.widx] : $urandom();
    req = r;
    p0_addr = h[0].addr; p0_acc_size = h[0].size; p0_wren = h[0].wren; p0_wdata = wd[0];
    p1_addr = h[1].addr; p1_acc_size = h[1].size; p1_wren = h[1].wren; p1_wdata = wd[1];
    mem_busy = busy_tab[cyc];
    mem_data_out = (mem_enable && !mem_wren) ? mem_rd(mem_addr + 32'(4 * ridx)) : $urandom();
    @(negedge clock);
    check_eq("gnt", 32'(gnt), 32'(e.gnt));
    check_eq("beat", 32'(beat), 32'(e.beat));
    check_eq("done", 32'(done), 32'(e.done));
    check_eq("mem_enable", 32'(mem_enable), 32'(e.en));
    check_eq("mem_wren", 32'(mem_wren), 32'(e.wren));
    check_eq("mem_addr", mem_addr, e.addr);
    check_eq("mem_acc_size", 32'(mem_acc_size), 32'(e.size));
    if (e.rd_chk) check_eq("rdata", rdata, e.rdata);
    if (e.wr_chk) check_eq("mem_data_in", mem_data_in, e.gnt[1] ? wd[1] : wd[0]);
    else if (!e.en) check_eq("mem_data_in_idle", mem_data_in, 32'h0);
    // Mem behaviour: write beats stored in order, read data LAT cycles after enable.
    if (mem_enable) begin
      if (mem_wren) begin
        if (!mem_busy) begin
          mem_st[mem_addr + 32'(4 * widx_m)] = mem_data_in;
          widx_m++;
        end
      end else begin
        if ((en_cnt >= LAT) && !mem_busy) ridx++;
        en_cnt++;
      end
    end else begin
      en_cnt = 0; ridx = 0; widx_m = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (beat[p]) obs_beats[p]++;
      if (act_end[p] == cyc) begin
        q_head[p]++;
        act_end[p] = -1;
      end
    end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (((q_head[0] != q_tail[0]) || (q_head[1] != q_tail[1]) || (cyc < next_free)) && (n < maxc)) begin
      step();
      n++;
    end
    check_eq("drain_bound", 32'(n < maxc), 32'h1);
    step();
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset_n = 1'b0;
    req = 2'b00;
    reset_model();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0][31:0] d;
    int b0, n;
    n_checks = 0; n_pass = 0; cyc = 0;
    for (int i = 0; i < NC; i++) busy_tab[i] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      q_head[p] = 0; q_tail[p] = 0; obs_beats[p] = 0;
    end
    reset_model();
    req = 2'b00; p0_addr = '0; p1_addr = '0; p0_acc_size = '0; p1_acc_size = '0;
    p0_wren = 1'b0; p1_wren = 1'b0; p0_wdata = '0; p1_wdata = '0;
    mem_data_out = '0; mem_busy = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_beat", 32'(beat), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_mem_enable", 32'(mem_enable), 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_data_in", mem_data_in, 32'h0);
    check_eq("rst_mem_acc_size", 32'(mem_acc_size), 32'h0);
    check_eq("rst_mem_wren", 32'(mem_wren), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single-word write then read-back on port 1.
    d = '0; d[0] = 32'h55CC_55CC;
    push(1, MEM_START_ADDR, 2'b00, 1'b1, d);
    drain(100);
    push(1, MEM_START_ADDR, 2'b00, 1'b0, d);
    drain(100);

    // Four-word burst on port 0.
    d = '0; d[0] = 32'h55CC_55CD; d[1] = 32'h55CC_55CE; d[2] = 32'h55CC_55CF; d[3] = 32'h55CC_55C1;
    push(0, MEM_START_ADDR + 32'h4, 2'b01, 1'b1, d);
    drain(100);
    push(0, MEM_START_ADDR + 32'h4, 2'b01, 1'b0, d);
    drain(100);

    // Simultaneous requests straight out of reset, port 1 re-requesting.
    reset_pulse();
    d = '0; d[0] = 32'h1111_0001; d[1] = 32'h1111_0002; d[2] = 32'h1111_0003; d[3] = 32'h1111_0004;
    push(0, MEM_START_ADDR + 32'h40, 2'b01, 1'b1, d);
    d = '0; d[0] = 32'h2222_0001;
    push(1, MEM_START_ADDR + 32'h80, 2'b00, 1'b1, d);
    d[0] = 32'h2222_0002;
    push(1, MEM_START_ADDR + 32'h84, 2'b00, 1'b1, d);
    drain(200);

    // Two-cycle busy stall in the middle of a 4-word read.
    busy_tab[cyc + 1 + LAT + 3] = 1'b1;
    busy_tab[cyc + 1 + LAT + 4] = 1'b1;
    b0 = obs_beats[0];
    push(0, MEM_START_ADDR + 32'h4, 2'b01, 1'b0, '0);
    drain(100);
    check_eq("stall_total_beats", 32'(obs_beats[0] - b0), 32'd4);

    // Reset during beat 2 of a 16-word write.
    d = '0;
    for (int i = 0; i < 16; i++) d[i] = $urandom();
    b0 = obs_beats[1];
    n = 0;
    push(1, MEM_START_ADDR + 32'h200, 2'b11, 1'b1, d);
    while (((obs_beats[1] - b0) < 2) && (n < 40)) begin
      step();
      n++;
    end
    check_eq("reach_beat2", 32'(n < 40), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("abort_mem_enable", 32'(mem_enable), 32'h0);
    check_eq("abort_gnt", 32'(gnt), 32'h0);
    check_eq("abort_beat", 32'(beat), 32'h0);
    check_eq("abort_done", 32'(done), 32'h0);
    reset_model();
    req = 2'b00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Fresh 8-word transaction after the abort.
    d = '0;
    for (int i = 0; i < 8; i++) d[i] = $urandom();
    push(0, MEM_START_ADDR + 32'h100, 2'b10, 1'b1, d);
    drain(100);
    push(0, MEM_START_ADDR + 32'h100, 2'b10, 1'b0, d);
    drain(100);

    // Random traffic on both ports with random busy.
    for (int i = cyc + 1; i < NC; i++) busy_tab[i] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 20; i++) begin
      for (int p = 0; p < 2; p++) begin
        d = '0;
        for (int j = 0; j < 16; j++) d[j] = $urandom();
        push(p, 32'h8003_0000 + 32'($urandom_range(0, 15) * 64), 2'($urandom()), 1'($urandom()), d);
      end
    end
    drain(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
